// File: rtl/soc_sonhamos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_sonhamos_pkg
//  Description : SoC-level address rule for the single external MMIO slot
//                that hosts the sonhamos timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_sonhamos_pkg;

  import sonhamos_timer_pkg::*;

  localparam logic [31:0] c_ext_peripheral_start_address = 32'hF000_0000;
  localparam int unsigned c_ext_num_peripherals          = 1;

  // Timer occupies window index 0 of the external peripheral demux
  localparam int unsigned c_timer_idx         = 0;
  localparam logic [31:0] c_timer_start_addr  = c_ext_peripheral_start_address;
  localparam logic [31:0] c_timer_end_addr    = c_ext_peripheral_start_address + c_reg_map_size;

endpackage : soc_sonhamos_pkg
`default_nettype wire

// File: rtl/sonhamos_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sonhamos_timer_pkg
//  Description : Register offsets, CTRL bit positions, register map size and
//                a byte-strobe merge helper for the sonhamos timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sonhamos_timer_pkg;

  // Register map size (one 4 KiB window)
  localparam logic [31:0] c_reg_map_size = 32'h0000_1000;

  // Register offsets within the window
  localparam logic [11:0] c_off_ctrl     = 12'h000;
  localparam logic [11:0] c_off_prescale = 12'h004;
  localparam logic [11:0] c_off_compare  = 12'h008;
  localparam logic [11:0] c_off_count    = 12'h00C;
  localparam logic [11:0] c_off_status   = 12'h010;

  // CTRL bit positions
  localparam int c_ctrl_en_bit      = 0;
  localparam int c_ctrl_clr_bit     = 1;
  localparam int c_ctrl_irq_en_bit  = 2;
  localparam int c_ctrl_oneshot_bit = 3;

  // STATUS bit positions
  localparam int c_status_match_bit = 0;

  // Merge write data into the current register image byte by byte
  function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage : sonhamos_timer_pkg
`default_nettype wire

// File: rtl/sonhamos_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : sonhamos_timer_prescaler
//  Description : Free-running prescaler; emits a one-cycle tick every
//                reload+1 enabled cycles. Holds while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module sonhamos_timer_prescaler
  import sonhamos_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] reload,
  input  logic                      clr,
  output logic                      tick
);

  localparam logic [PRESCALE_WIDTH-1:0] c_ps_one = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      w_at_reload;

  assign w_at_reload = (r_cnt == reload);
  assign tick        = en & w_at_reload;

  // Prescaler count: clear wins, then reload-on-terminal or increment while enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_reload ? '0 : (r_cnt + c_ps_one);
    end
  end

endmodule : sonhamos_timer_prescaler
`default_nettype wire

// File: rtl/sonhamos_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sonhamos_timer
//  Description : Reg-bus timer/compare peripheral with prescaler, sticky
//                match flag, one-shot/periodic modes and level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module sonhamos_timer
  import sonhamos_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        reg_valid_i,
  input  logic        reg_write_i,
  input  logic [3:0]  reg_wstrb_i,
  input  logic [31:0] reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_error_o,
  output logic        reg_ready_o,
  output logic        irq_o
);

  localparam logic [COUNT_WIDTH-1:0] c_count_one = COUNT_WIDTH'(1);

  // Architectural state
  logic                      r_en;
  logic                      r_irq_en;
  logic                      r_oneshot;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [COUNT_WIDTH-1:0]    r_compare;
  logic [COUNT_WIDTH-1:0]    r_count;
  logic                      r_match;
  logic                      r_irq;

  // Decode
  logic [11:0] w_off;
  logic        w_hit_ctrl, w_hit_ps, w_hit_cmp, w_hit_cnt, w_hit_stat;
  logic        w_addr_ok;
  logic        w_wr;

  // Register read images and write-merged values
  logic [31:0] w_ctrl_rd, w_ps_rd, w_cmp_rd, w_cnt_rd, w_stat_rd;
  logic [31:0] w_ctrl_wval, w_ps_wval, w_cmp_wval, w_stat_wval;
  logic        w_ctrl_we, w_ps_we, w_cmp_we, w_stat_we;

  // Timer datapath
  logic                   w_tick;
  logic                   w_clr;
  logic                   w_at_cmp;
  logic                   w_match_evt;
  logic                   w_en_nxt, w_irq_en_nxt, w_oneshot_nxt, w_match_nxt;
  logic [COUNT_WIDTH-1:0] w_count_nxt;
  logic                   w_unused_bits;

  // Exact offset match also rejects misaligned addresses
  assign w_off      = reg_addr_i[11:0];
  assign w_hit_ctrl = (w_off == c_off_ctrl);
  assign w_hit_ps   = (w_off == c_off_prescale);
  assign w_hit_cmp  = (w_off == c_off_compare);
  assign w_hit_cnt  = (w_off == c_off_count);
  assign w_hit_stat = (w_off == c_off_status);
  assign w_addr_ok  = w_hit_ctrl | w_hit_ps | w_hit_cmp | w_hit_cnt | w_hit_stat;
  assign w_wr       = reg_valid_i & reg_write_i & w_addr_ok;

  assign reg_ready_o = reg_valid_i;
  assign reg_error_o = reg_valid_i & ~w_addr_ok;

  // Zero-extended register images; CLR always reads 0
  always_comb begin
    w_ctrl_rd                      = '0;
    w_ctrl_rd[c_ctrl_en_bit]       = r_en;
    w_ctrl_rd[c_ctrl_irq_en_bit]   = r_irq_en;
    w_ctrl_rd[c_ctrl_oneshot_bit]  = r_oneshot;
    w_ps_rd                        = '0;
    w_ps_rd[PRESCALE_WIDTH-1:0]    = r_prescale;
    w_cmp_rd                       = '0;
    w_cmp_rd[COUNT_WIDTH-1:0]      = r_compare;
    w_cnt_rd                       = '0;
    w_cnt_rd[COUNT_WIDTH-1:0]      = r_count;
    w_stat_rd                      = '0;
    w_stat_rd[c_status_match_bit]  = r_match;
  end

  // Read data mux, zero unless a valid in-map access is presented
  always_comb begin
    reg_rdata_o = '0;
    if (reg_valid_i) begin
      if (w_hit_ctrl)      reg_rdata_o = w_ctrl_rd;
      else if (w_hit_ps)   reg_rdata_o = w_ps_rd;
      else if (w_hit_cmp)  reg_rdata_o = w_cmp_rd;
      else if (w_hit_cnt)  reg_rdata_o = w_cnt_rd;
      else if (w_hit_stat) reg_rdata_o = w_stat_rd;
    end
  end

  assign w_ctrl_wval = apply_wstrb(w_ctrl_rd, reg_wdata_i, reg_wstrb_i);
  assign w_ps_wval   = apply_wstrb(w_ps_rd,   reg_wdata_i, reg_wstrb_i);
  assign w_cmp_wval  = apply_wstrb(w_cmp_rd,  reg_wdata_i, reg_wstrb_i);
  // STATUS is W1C: merge onto zero so only written ones clear
  assign w_stat_wval = apply_wstrb(32'h0,     reg_wdata_i, reg_wstrb_i);

  assign w_ctrl_we = w_wr & w_hit_ctrl;
  assign w_ps_we   = w_wr & w_hit_ps;
  assign w_cmp_we  = w_wr & w_hit_cmp;
  assign w_stat_we = w_wr & w_hit_stat;

  assign w_clr = w_ctrl_we & w_ctrl_wval[c_ctrl_clr_bit];

  assign w_unused_bits = ^{reg_addr_i[31:12], w_ps_wval, w_cmp_wval, w_ctrl_wval, w_stat_wval};

  sonhamos_timer_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (r_en),
    .reload (r_prescale),
    .clr    (w_clr),
    .tick   (w_tick)
  );

  // A tick coinciding with CLR is dropped entirely
  assign w_at_cmp    = (r_count == r_compare);
  assign w_match_evt = w_tick & w_at_cmp & ~w_clr;

  // Next-state: hardware events first, bus writes override CTRL, match set beats W1C
  always_comb begin
    w_en_nxt      = r_en;
    w_irq_en_nxt  = r_irq_en;
    w_oneshot_nxt = r_oneshot;
    w_match_nxt   = r_match;
    w_count_nxt   = r_count;

    if (w_match_evt && r_oneshot) begin
      w_en_nxt = 1'b0;
    end
    if (w_ctrl_we) begin
      w_en_nxt      = w_ctrl_wval[c_ctrl_en_bit];
      w_irq_en_nxt  = w_ctrl_wval[c_ctrl_irq_en_bit];
      w_oneshot_nxt = w_ctrl_wval[c_ctrl_oneshot_bit];
    end

    if (w_stat_we && w_stat_wval[c_status_match_bit]) begin
      w_match_nxt = 1'b0;
    end
    if (w_match_evt) begin
      w_match_nxt = 1'b1;
    end

    if (w_clr) begin
      w_count_nxt = '0;
    end else if (w_tick) begin
      w_count_nxt = w_at_cmp ? '0 : (r_count + c_count_one);
    end
  end

  // State registers, including the registered interrupt level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_oneshot  <= 1'b0;
      r_prescale <= '0;
      r_compare  <= '1;
      r_count    <= '0;
      r_match    <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_en      <= w_en_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_oneshot <= w_oneshot_nxt;
      r_count   <= w_count_nxt;
      r_match   <= w_match_nxt;
      r_irq     <= w_match_nxt & w_irq_en_nxt;
      if (w_ps_we) begin
        r_prescale <= w_ps_wval[PRESCALE_WIDTH-1:0];
      end
      if (w_cmp_we) begin
        r_compare <= w_cmp_wval[COUNT_WIDTH-1:0];
      end
    end
  end

  assign irq_o = r_irq;

endmodule : sonhamos_timer
`default_nettype wire

// File: tb/tb_sonhamos_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sonhamos_timer
//  Description : Scoreboard bench for sonhamos_timer. The driver pushes the
//                expected response of each bus access; a negedge monitor pops
//                and compares while the access is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sonhamos_timer;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_PS   = 32'h04;
  localparam logic [31:0] A_CMP  = 32'h08;
  localparam logic [31:0] A_CNT  = 32'h0C;
  localparam logic [31:0] A_STAT = 32'h10;

  logic        clk;
  logic        rst_n;
  logic        reg_valid;
  logic        reg_write;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic        reg_ready;
  logic        irq;

  typedef struct {
    string       name;
    logic        chk_data;
    logic [31:0] data;
    logic        err;
    logic        chk_irq;
    logic        irq;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic done     = 1'b0;
  logic reported = 1'b0;

  sonhamos_timer #(
    .PRESCALE_WIDTH (16),
    .COUNT_WIDTH    (32)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .reg_valid_i (reg_valid),
    .reg_write_i (reg_write),
    .reg_wstrb_i (reg_wstrb),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .reg_error_o (reg_error),
    .reg_ready_o (reg_ready),
    .irq_o       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare presented responses, and idle bus outputs, at negedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: access at addr %h with no expectation", reg_addr);
        end else begin
          e = q.pop_front();
          if (reg_ready !== 1'b1 || reg_error !== e.err ||
              (e.chk_data && reg_rdata !== e.data) ||
              (e.chk_irq && irq !== e.irq)) begin
            errors++;
            $display("FAIL %s: got rdata=%h err=%b rdy=%b irq=%b, expected rdata=%h err=%b irq=%b",
                     e.name, reg_rdata, reg_error, reg_ready, irq,
                     e.data, e.err, e.irq);
          end
        end
      end else begin
        checks++;
        if (reg_ready !== 1'b0 || reg_error !== 1'b0 || reg_rdata !== 32'h0) begin
          errors++;
          $display("FAIL idle_bus: got rdata=%h err=%b rdy=%b, expected all 0",
                   reg_rdata, reg_error, reg_ready);
        end
      end
    end
    if (done && !reported) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      end
      reported = 1'b1;
    end
  end

  // One bus access: starts just after a posedge, lasts exactly one cycle
  task automatic acc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic cd, input logic [31:0] ed,
                     input logic ee, input logic ci, input logic ei, input string nm);
    exp_t x;
    x.name = nm; x.chk_data = cd; x.data = ed; x.err = ee; x.chk_irq = ci; x.irq = ei;
    q.push_back(x);
    reg_valid = 1'b1;
    reg_write = wr;
    reg_addr  = addr;
    reg_wdata = wdata;
    reg_wstrb = strb;
    @(posedge clk); #1;
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input string nm);
    acc(1'b0, a, 32'h0, 4'h0, 1'b1, d, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic rd_irq(input logic [31:0] a, input logic [31:0] d, input logic i, input string nm);
    acc(1'b0, a, 32'h0, 4'h0, 1'b1, d, 1'b0, 1'b1, i, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    acc(1'b1, a, d, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; reg_valid = 1'b0; reg_write = 1'b0;
    reg_wstrb = 4'h0; reg_addr = 32'h0; reg_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset defaults
    rd_irq(A_CTRL, 32'h0,        1'b0, "rst_ctrl");
    rd_irq(A_PS,   32'h0,        1'b0, "rst_prescale");
    rd_irq(A_CMP,  32'hFFFFFFFF, 1'b0, "rst_compare");
    rd_irq(A_CNT,  32'h0,        1'b0, "rst_count");
    rd_irq(A_STAT, 32'h0,        1'b0, "rst_status");

    // Periodic: PRESCALE=3, COMPARE=4 -> match 20 cycles after EN
    wr(A_PS,   32'h3, "per_ps");
    wr(A_CMP,  32'h4, "per_cmp");
    wr(A_CTRL, 32'h5, "per_ctrl");                 // cycle 0
    idle(19);                                      // cycles 1..19
    rd_irq(A_STAT, 32'h0, 1'b0, "per_pre_match");  // 20
    rd(A_STAT, 32'h1, "per_match");                // 21
    rd_irq(A_CNT, 32'h0, 1'b1, "per_cnt_wrap");    // 22
    wr(A_STAT, 32'h1, "per_w1c");                  // 23
    rd(A_STAT, 32'h0, "per_cleared");              // 24
    idle(15);                                      // 25..39
    rd(A_STAT, 32'h0, "per_pre_match2");           // 40
    rd(A_STAT, 32'h1, "per_match2");               // 41

    // W1C in the exact match cycle: set wins
    wr(A_STAT, 32'h1, "col_clear");                // 42
    rd(A_STAT, 32'h0, "col_cleared");              // 43
    idle(16);                                      // 44..59
    acc(1'b1, A_STAT, 32'h1, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, "col_w1c_at_match"); // 60
    rd(A_STAT, 32'h1, "col_set_wins");             // 61
    acc(1'b1, A_STAT, 32'h1, 4'hF, 1'b1, 32'h1, 1'b0, 1'b1, 1'b1, "col_w1c_irq_high"); // 62
    rd(A_STAT, 32'h0, "col_match_cleared");        // 63
    rd_irq(A_STAT, 32'h0, 1'b0, "col_irq_low");    // 64
    wr(A_CTRL, 32'h0, "col_disable");

    // One-shot: PRESCALE=0, COMPARE=2 -> match on 3rd tick, EN self-clears
    wr(A_CTRL, 32'h2, "os_clr");
    wr(A_STAT, 32'h1, "os_w1c");
    wr(A_PS,   32'h0, "os_ps");
    wr(A_CMP,  32'h2, "os_cmp");
    wr(A_CTRL, 32'h9, "os_ctrl");                  // cycle 0
    rd(A_STAT, 32'h0, "os_no_match");              // 1
    rd(A_CNT,  32'h1, "os_cnt1");                  // 2
    rd(A_CNT,  32'h2, "os_cnt2");                  // 3
    rd_irq(A_STAT, 32'h1, 1'b0, "os_match_noirq"); // 4
    rd(A_CTRL, 32'h8, "os_en_cleared");            // 5
    idle(50);
    rd(A_CNT,  32'h0, "os_cnt_held");

    // CLR versus coincident tick at COUNT=7
    wr(A_CTRL, 32'h2, "clr_prep");
    wr(A_STAT, 32'h1, "clr_w1c");
    wr(A_CMP,  32'd100, "clr_cmp");
    wr(A_CTRL, 32'h1, "clr_en");                   // cycle 0
    idle(6);                                       // 1..6
    rd(A_CNT, 32'h6, "clr_cnt6");                  // 7
    acc(1'b1, A_CTRL, 32'h3, 4'hF, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, "clr_write"); // 8
    rd(A_CNT,  32'h0, "clr_cnt_zero");             // 9
    rd(A_CTRL, 32'h1, "clr_en_kept");              // 10
    rd(A_CNT,  32'h2, "clr_resume");               // 11

    // Bus errors, RO write, byte strobes, address aliasing
    wr(A_CTRL, 32'h2, "bus_stop");
    acc(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "bus_rd_0x14");
    acc(1'b0, 32'h02, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "bus_rd_0x02");
    acc(1'b0, 32'h800, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "bus_rd_0x800");
    acc(1'b1, A_CNT, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "bus_wr_count");
    rd(A_CNT, 32'h0, "bus_count_unchanged");
    acc(1'b1, A_PS, 32'hABCD, 4'h1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "bus_ps_strb");
    rd(A_PS, 32'h00CD, "bus_ps_byte0");
    acc(1'b1, 32'h05, 32'hFF, 4'hF, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "bus_wr_misaligned");
    acc(1'b1, 32'h14, 32'hFF, 4'hF, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "bus_wr_unmapped");
    rd(A_PS, 32'h00CD, "bus_ps_no_change");
    rd(32'h0000_1004, 32'h00CD, "bus_alias_upper_bits");
    acc(1'b1, A_CMP, 32'h0000AA00, 4'h2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "bus_cmp_strb");
    rd(A_CMP, 32'h0000AA64, "bus_cmp_byte1");

    // Reset in the middle of a count
    wr(A_PS,   32'h0, "mid_ps");
    wr(A_CTRL, 32'h5, "mid_en");
    idle(5);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rd(A_CTRL, 32'h0,        "mid_ctrl");
    rd(A_PS,   32'h0,        "mid_ps_rst");
    rd(A_CMP,  32'hFFFFFFFF, "mid_cmp");
    rd(A_CNT,  32'h0,        "mid_cnt");
    rd_irq(A_STAT, 32'h0, 1'b0, "mid_status");

    idle(2);
    done = 1'b1;
    for (int i = 0; i < 10 && !reported; i++) begin
      @(posedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sonhamos_timer
`default_nettype wire

// File: doc/sonhamos_timer.md
Name: sonhamos_timer

Overview:
- Timer/compare peripheral that occupies the single external MMIO slot: window index 0, base EXT_PERIPHERAL_START_ADDRESS, 4 KiB.
- Consumes the reg-bus request routed to that slot by the external peripheral demux and returns a reg-bus response.
- Provides a prescaled up-counter, a compare match, one-shot/periodic modes and a level interrupt to the X-HEEP external interrupt vector.

Parameters:
- PRESCALE_WIDTH, 16, width of the prescaler reload register and prescaler counter.
- COUNT_WIDTH, 32, width of the main counter and COMPARE; legal range 1..32.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- reg_valid_i  in  1  request valid (reg_req_t.valid).
- reg_write_i  in  1  1 = write, 0 = read.
- reg_wstrb_i  in  4  byte enables for writes.
- reg_addr_i  in  32  byte address; only bits [11:0] are decoded.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data (reg_rsp_t.rdata).
- reg_error_o  out  1  response error.
- reg_ready_o  out  1  response ready.
- irq_o  out  1  level interrupt.

Behaviour:
- Clock domain: one clock. Every flop resets asynchronously on rst_ni low.
- Reset values: CTRL=0, PRESCALE=0, COMPARE=all ones, prescaler counter=0, COUNT=0, MATCH=0, irq_o=0.
- Bus: reg_ready_o = reg_valid_i, combinational, so every access completes in the cycle it is presented.
  - reg_rdata_o and reg_error_o are combinational from the address; both are 0 when reg_valid_i=0.
  - Writes take effect at the clock edge of the accepted cycle.
  - wstrb is applied per byte.
  - Any addr[1:0] != 0, or any offset outside the map: error=1, rdata=0, no state change.
- Register map (offsets):
  - 0x00 CTRL, RW:
    - bit0 EN.
    - bit1 CLR: write-1 pulse, always reads 0.
    - bit2 IRQ_EN.
    - bit3 ONESHOT.
    - Other bits read 0.
  - 0x04 PRESCALE, RW, [PRESCALE_WIDTH-1:0]; upper bits read 0.
  - 0x08 COMPARE, RW, [COUNT_WIDTH-1:0].
  - 0x0C COUNT, RO. Writes are ignored with error=0.
  - 0x10 STATUS: bit0 MATCH, sticky, write-1-to-clear.
- Prescaler:
  - When EN=1, the prescaler counter increments every cycle.
  - When it equals PRESCALE, it reloads to 0 and asserts a one-cycle tick.
  - So tick period = PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
  - When EN=0, the prescaler counter holds its value.
- Counter, evaluated on tick:
  - If COUNT == COMPARE: COUNT <= 0 and MATCH <= 1. If ONESHOT=1, EN is also cleared in the same edge.
  - Otherwise COUNT <= COUNT+1. Arithmetic is modulo 2^COUNT_WIDTH; no overflow flag.
- CLR write: the prescaler counter and COUNT both go to 0 on that edge. CLR overrides a coincident tick.
  - CLR does not affect MATCH or any other CTRL bit written in the same access.
- Simultaneous events:
  - A STATUS W1C write in the same cycle as a match leaves MATCH=1 (set wins).
  - A CTRL write in the same cycle as a one-shot match uses the written EN value (bus wins).
  - A COMPARE write takes effect for comparisons from the next cycle onward.
  - If COMPARE is written below the current COUNT, the counter runs up through the wrap to reach the match.
- irq_o: registered, irq_o <= MATCH_next & IRQ_EN_next. It asserts one cycle after MATCH sets and deasserts one cycle after MATCH clears or IRQ_EN drops.
- Reset mid-count: all state returns to reset values immediately. No bus response is owed for a request in flight during reset.

Decomposition:
- New package sonhamos_timer_pkg holds:
  - register offset constants;
  - CTRL bit index constants;
  - the register map size, 32'h1000.
- soc_sonhamos_pkg keeps the address rule and references the size constant.
- One sub-module, sonhamos_timer_prescaler: en, reload and clr inputs; tick output; parameterized by PRESCALE_WIDTH.

Test Plan:
1. Reset defaults: hold rst_ni low, then release. Read all five offsets -> 0, 0, 0xFFFFFFFF, 0, 0. irq_o=0 and error=0 throughout.
2. Periodic match:
   - Stimulus: PRESCALE=3, COMPARE=4, CTRL=0x5 (EN, IRQ_EN).
   - MATCH sets 20 cycles after EN goes high. irq_o rises 1 cycle later.
   - COUNT reads 0 after the match, and the next match follows 20 cycles later.
3. One-shot:
   - Stimulus: PRESCALE=0, COMPARE=2, CTRL=0x9 (EN, ONESHOT).
   - MATCH sets on the 3rd tick, EN then reads 0, and COUNT stays 0 for the next 50 cycles.
4. W1C/set collision: write STATUS=1 in the exact match cycle -> MATCH reads 1. A later STATUS=1 write -> MATCH 0, and irq_o falls 1 cycle after.
5. CLR versus tick: with PRESCALE=0 and COUNT=7, write CTRL=0x3 -> COUNT reads 0 in the next cycle, and EN remains 1.
6. Bus errors:
   - Read at 0x14 -> error=1, rdata=0.
   - Read at 0x02 -> error=1.
   - Write at 0x0C -> error=0 and COUNT is unchanged.
   - Write PRESCALE with wstrb=0x1 and wdata=0xABCD -> reads 0x00CD.
